uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter among N_REQ requesters.
- Each requester offers one byte plus parity configuration. The arbiter picks one requester round-robin, loads the transmitter's data_in/parity_en/even_parity and pulses tx_start.
- It then tracks the transmitter's tx_busy until the frame completes and reports completion to the owning requester.
- Sits between client logic and the UART TX datapath.

---
 rtl/uart_tx_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares a single UART transmitter among N_REQ requesters. A round-robin pick
// in IDLE captures the winner's byte and parity settings, the transmitter is
// launched with a one-cycle tx_start, and the frame is followed via tx_busy
// until it finishes (done) or never starts (timeout).
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int DATA_W       = 8,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    input  logic [N_REQ-1:0]         req_parity_en,
    input  logic [N_REQ-1:0]         req_even_parity,
    output logic [N_REQ-1:0]         grant,
    output logic [N_REQ-1:0]         done,
    output logic                     timeout,
    input  logic                     tx_busy,
    output logic                     tx_start,
    output logic [DATA_W-1:0]        data_in,
    output logic                     parity_en,
    output logic                     even_parity,
    output logic [$clog2(N_REQ)-1:0] owner
);

    localparam int OWN_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    // Index following i, wrapping at N_REQ (N_REQ need not be a power of two).
    function automatic logic [OWN_W-1:0] next_idx(input logic [OWN_W-1:0] i);
        logic [OWN_W-1:0] r;
        if (i == OWN_W'(N_REQ - 1)) begin
            r = '0;
        end else begin
            r = i + 1'b1;
        end
        return r;
    endfunction

    // One-hot vector with bit i set.
    function automatic logic [N_REQ-1:0] onehot(input logic [OWN_W-1:0] i);
        return N_REQ'(1) << i;
    endfunction

    // First requester found scanning ptr, ptr+1, ... with wrap.
    function automatic logic [OWN_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                  input logic [OWN_W-1:0] ptr);
        logic [OWN_W-1:0] idx;
        logic [OWN_W-1:0] sel;
        logic             found;
        idx   = ptr;
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && r[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
            idx = next_idx(idx);
        end
        return sel;
    endfunction

    // Byte lane of the selected requester.
    function automatic logic [DATA_W-1:0] pick_data(input logic [N_REQ*DATA_W-1:0] d,
                                                     input logic [OWN_W-1:0]        sel);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (OWN_W'(k) == sel) begin
                r = d[k*DATA_W +: DATA_W];
            end
        end
        return r;
    endfunction

    state_t               state_q, state_d;
    logic [OWN_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [OWN_W-1:0]     owner_q, owner_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_REQ-1:0]     grant_q, grant_d;
    logic [N_REQ-1:0]     done_q, done_d;
    logic                 timeout_q, timeout_d;
    logic                 tx_start_q, tx_start_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 parity_en_q, parity_en_d;
    logic                 even_parity_q, even_parity_d;

    logic [OWN_W-1:0]     pick;
    logic [DATA_W-1:0]    pick_byte;

    assign pick      = rr_pick(req, rr_ptr_q);
    assign pick_byte = pick_data(req_data, pick);

    // Next-state and next-output logic; every output is a registered pulse or level.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        data_d        = data_q;
        parity_en_d   = parity_en_q;
        even_parity_d = even_parity_q;
        grant_d       = '0;
        done_d        = '0;
        timeout_d     = 1'b0;
        tx_start_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A frame still on the line (foreign or leftover) blocks new grants.
                if (!tx_busy && (req != '0)) begin
                    owner_d       = pick;
                    data_d        = pick_byte;
                    parity_en_d   = req_parity_en[pick];
                    even_parity_d = req_even_parity[pick];
                    grant_d       = onehot(pick);
                    state_d       = ST_LAUNCH;
                end
            end

            ST_LAUNCH: begin
                tx_start_d = 1'b1;
                cnt_d      = '0;
                state_d    = ST_WAIT_BUSY;
            end

            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // Transmitter never acknowledged: give up and move priority on.
                    timeout_d = 1'b1;
                    rr_ptr_d  = next_idx(owner_q);
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    done_d   = onehot(owner_q);
                    rr_ptr_d = next_idx(owner_q);
                    state_d  = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any frame without reporting it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            cnt_q         <= '0;
            grant_q       <= '0;
            done_q        <= '0;
            timeout_q     <= 1'b0;
            tx_start_q    <= 1'b0;
            data_q        <= '0;
            parity_en_q   <= 1'b0;
            even_parity_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            grant_q       <= grant_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
            tx_start_q    <= tx_start_d;
            data_q        <= data_d;
            parity_en_q   <= parity_en_d;
            even_parity_q <= even_parity_d;
        end
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign tx_start    = tx_start_q;
    assign data_in     = data_q;
    assign parity_en   = parity_en_q;
    assign even_parity = even_parity_q;
    assign owner       = owner_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Directed scenarios followed by randomized traffic. A transaction-level
// reference (pick, launch, wait for busy, wait for idle) predicts every output
// each cycle; a transmitter stand-in answers tx_start with a busy window.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BT = 4;
    localparam int OW = 2;

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N-1:0]         req;
    logic [N-1:0][DW-1:0] req_data_a;
    logic [N-1:0]         req_pe;
    logic [N-1:0]         req_ev;
    logic [N-1:0]         grant;
    logic [N-1:0]         done;
    logic                 timeout;
    logic                 tx_busy;
    logic                 tx_start;
    logic [DW-1:0]        data_in;
    logic                 parity_en;
    logic                 even_parity;
    logic [OW-1:0]        owner;

    logic resp_busy  = 1'b0;
    logic busy_force = 1'b0;
    assign tx_busy = resp_busy | busy_force;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .BUSY_TIMEOUT(BT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req             (req),
        .req_data        (req_data_a),
        .req_parity_en   (req_pe),
        .req_even_parity (req_ev),
        .grant           (grant),
        .done            (done),
        .timeout         (timeout),
        .tx_busy         (tx_busy),
        .tx_start        (tx_start),
        .data_in         (data_in),
        .parity_en       (parity_en),
        .even_parity     (even_parity),
        .owner           (owner)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // ---------------- transmitter stand-in ----------------
    bit xm_respond = 1'b1;
    bit xm_rand    = 1'b0;
    int xm_lat     = 1;
    int xm_len     = 11;
    int xs         = -1;
    int xe         = -1;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && tx_start && xm_respond) begin
                if (xm_rand) begin
                    xm_lat = $urandom_range(BT + 1, 1);
                    xm_len = $urandom_range(6, 1);
                end
                xs = cyc + xm_lat;
                xe = xs + xm_len;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                xs = -1;
                xe = -1;
            end
            resp_busy = (cyc >= xs) && (cyc < xe);
        end
    end

    // ---------------- reference model ----------------
    logic [N-1:0]  e_grant, e_done;
    logic          e_timeout, e_start;
    logic [OW-1:0] e_owner;
    logic [DW-1:0] e_data;
    logic          e_pe, e_ev;
    int            m_ptr;

    task automatic m_clear();
        e_grant   = '0;
        e_done    = '0;
        e_timeout = 1'b0;
        e_start   = 1'b0;
    endtask

    task automatic m_reset();
        m_clear();
        e_owner = '0;
        e_data  = '0;
        e_pe    = 1'b0;
        e_ev    = 1'b0;
        m_ptr   = 0;
    endtask

    task automatic m_step(output bit ab);
        @(posedge clk);
        m_clear();
        ab = !rst_n;
        if (ab) m_reset();
    endtask

    initial begin : model
        bit ab;
        bit rose;
        int pk;
        int ix;
        m_reset();
        forever begin
            m_step(ab);
            if (ab) continue;
            if (tx_busy || (req == '0)) continue;
            pk = -1;
            for (int k = 0; k < N; k++) begin
                ix = (m_ptr + k) % N;
                if (pk < 0 && req[ix[OW-1:0]]) pk = ix;
            end
            e_grant = N'(1) << pk;
            e_owner = pk[OW-1:0];
            e_data  = req_data_a[pk[OW-1:0]];
            e_pe    = req_pe[pk[OW-1:0]];
            e_ev    = req_ev[pk[OW-1:0]];
            m_step(ab);
            if (ab) continue;
            e_start = 1'b1;
            rose = 1'b0;
            for (int c = 0; c < BT; c++) begin
                m_step(ab);
                if (ab) break;
                if (tx_busy) begin
                    rose = 1'b1;
                    break;
                end
            end
            if (ab) continue;
            if (!rose) begin
                e_timeout = 1'b1;
                m_ptr = (pk + 1) % N;
                continue;
            end
            forever begin
                m_step(ab);
                if (ab) break;
                if (!tx_busy) break;
            end
            if (ab) continue;
            e_done = N'(1) << pk;
            m_ptr  = (pk + 1) % N;
        end
    end

    // ---------------- per-cycle comparison ----------------
    initial begin : compare
        logic [N-1:0]  xg, xd;
        logic          xt, xst, xpe, xev;
        logic [OW-1:0] xo;
        logic [DW-1:0] xdat;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                {xg, xd, xt, xst, xo, xdat, xpe, xev} = '0;
            end else begin
                {xg, xd, xt, xst, xo, xdat, xpe, xev} =
                    {e_grant, e_done, e_timeout, e_start, e_owner, e_data, e_pe, e_ev};
            end
            check("grant",       32'(grant),       32'(xg));
            check("done",        32'(done),        32'(xd));
            check("timeout",     32'(timeout),     32'(xt));
            check("tx_start",    32'(tx_start),    32'(xst));
            check("owner",       32'(owner),       32'(xo));
            check("data_in",     32'(data_in),     32'(xdat));
            check("parity_en",   32'(parity_en),   32'(xpe));
            check("even_parity", 32'(even_parity), 32'(xev));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_grant(input logic [N-1:0] exp, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (grant == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(grant), 32'(exp));
    endtask

    task automatic wait_end(input string name, output int kind);
        int n;
        kind = 0;
        n = 0;
        while (kind == 0 && n < 80) begin
            @(negedge clk);
            n++;
            if (done != '0) kind = 1;
            else if (timeout) kind = 2;
            else if (grant != '0) check({name, "_overlap"}, 32'(grant), 32'(0));
        end
        if (kind == 0) fail_now(name);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int kind;
        int n;
        logic [N-1:0] m;
        req        = '0;
        req_data_a = '0;
        req_pe     = '0;
        req_ev     = '0;
        repeat (3) tick();
        check("reset_owner", 32'(owner), 32'(0));
        check("reset_data", 32'(data_in), 32'(0));
        rst_n = 1'b1;

        // Round robin with all four requesting continuously.
        tick();
        req        = 4'hF;
        req_data_a = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int g = 0; g < 5; g++) begin
            wait_grant(N'(1) << (g % N), "rr_grant");
            if (g == 4) begin
                tick();
                req = '0;
            end
            wait_end("rr_end", kind);
            check("rr_end_kind", 32'(kind), 32'(1));
        end

        // Single request with parity, rr pointer now at 1.
        tick();
        req           = 4'b0010;
        req_data_a[1] = 8'hA5;
        req_pe        = 4'b0010;
        req_ev        = 4'b0010;
        wait_grant(4'b0010, "single_grant");
        tick();
        req = '0;
        @(negedge clk);
        check("single_start", 32'(tx_start), 32'(1));
        check("single_data", 32'(data_in), 32'(8'hA5));
        check("single_pe", 32'(parity_en), 32'(1));
        check("single_ev", 32'(even_parity), 32'(1));
        n = 0;
        while (done == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("single_done_vec", 32'(done), 32'(4'b0010));
        check("single_done_lat", 32'(n), 32'(13));

        // Priority rotation: serve 2, then 0 and 2 together -> 0 then 2.
        tick();
        req = 4'b0100;
        wait_grant(4'b0100, "rot_serve2");
        tick();
        req = '0;
        wait_end("rot_end0", kind);
        tick();
        req = 4'b0101;
        wait_grant(4'b0001, "rot_first");
        tick();
        req = 4'b0100;
        wait_end("rot_end1", kind);
        wait_grant(4'b0100, "rot_second");
        tick();
        req = '0;
        wait_end("rot_end2", kind);

        // Timeout: transmitter never answers.
        xm_respond = 1'b0;
        tick();
        req = 4'b0001;
        wait_grant(4'b0001, "to_grant");
        tick();
        req = '0;
        @(negedge clk);
        check("to_start", 32'(tx_start), 32'(1));
        n = 0;
        while (!timeout && done == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("to_pulse", 32'(timeout), 32'(1));
        check("to_lat", 32'(n), 32'(BT));
        check("to_nodone", 32'(done), 32'(0));
        xm_respond = 1'b1;
        tick();
        req = 4'b0011;
        wait_grant(4'b0010, "to_next");
        tick();
        req = '0;
        wait_end("to_end", kind);

        // Busy at idle: no grant while tx_busy is held high.
        tick();
        busy_force = 1'b1;
        req        = 4'b1000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bi_hold", 32'(grant), 32'(0));
        end
        tick();
        busy_force = 1'b0;
        wait_grant(4'b1000, "bi_grant");
        tick();
        req = '0;
        wait_end("bi_end", kind);

        // Reset during WAIT_DONE.
        tick();
        req           = 4'b0001;
        req_data_a[0] = 8'h5A;
        req_pe        = 4'b0001;
        req_ev        = 4'b0001;
        wait_grant(4'b0001, "rst_grant");
        tick();
        req = '0;
        n = 0;
        while (!tx_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("rst_pre_data", 32'(data_in), 32'(8'h5A));
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_start", 32'(tx_start), 32'(0));
        check("rst_data", 32'(data_in), 32'(0));
        check("rst_pe", 32'(parity_en), 32'(0));
        check("rst_ev", 32'(even_parity), 32'(0));
        check("rst_grant", 32'(grant), 32'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_nodone", 32'(done), 32'(0));
        end
        tick();
        req = 4'b0100;
        wait_grant(4'b0100, "rst_first");
        tick();
        req = '0;
        wait_end("rst_end", kind);

        // Randomized traffic checked by the reference model.
        xm_rand = 1'b1;
        for (int cy = 0; cy < 4000; cy++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                m = N'(1) << i;
                if ((grant & m) != '0) begin
                    if ($urandom_range(3, 0) != 0) req = req & ~m;
                end else if ((req & m) == '0) begin
                    if ($urandom_range(5, 0) == 0) begin
                        req = req | m;
                        req_data_a[i[OW-1:0]] = DW'($urandom);
                        req_pe[i[OW-1:0]]     = 1'($urandom);
                        req_ev[i[OW-1:0]]     = 1'($urandom);
                    end
                end else if ($urandom_range(40, 0) == 0) begin
                    req = req & ~m;
                end
            end
            if (busy_force) begin
                if ($urandom_range(3, 0) == 0) busy_force = 1'b0;
            end else if ($urandom_range(150, 0) == 0) begin
                busy_force = 1'b1;
            end
            if ($urandom_range(700, 0) == 0) begin
                rst_n = 1'b0;
                tick();
                tick();
                rst_n = 1'b1;
            end
        end
        req        = '0;
        busy_force = 1'b0;
        repeat (40) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
